// File: rtl/alu_seq_exec.sv
// Sequential ALU execute stage: single-cycle logic/arithmetic ops, and shifts
// that move one bit position per cycle. The result and Zero flag are registered.
package alu_seq_pkg;
  localparam logic [3:0] ALU_NONE             = 4'd0;
  localparam logic [3:0] ALU_ADD              = 4'd1;
  localparam logic [3:0] ALU_SUB              = 4'd2;
  localparam logic [3:0] ALU_XOR              = 4'd3;
  localparam logic [3:0] ALU_OR               = 4'd4;
  localparam logic [3:0] ALU_AND              = 4'd5;
  localparam logic [3:0] ALU_SHIFTL           = 4'd6;
  localparam logic [3:0] ALU_SHIFTR           = 4'd7;
  localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd8;
  localparam logic [3:0] ALU_LESS_THAN        = 4'd9;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

module alu_seq_exec
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] single_res;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SHIFTL) || (ctrl == ALU_SHIFTR) || (ctrl == ALU_SHIFTR_ARITH);
  endfunction

  // Shift codes return A here; this path is only taken for a zero shift amount.
  function automatic logic [WIDTH-1:0] single_op(input logic [3:0]       ctrl,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    unique case (ctrl)
      ALU_NONE:             return b;
      ALU_ADD:              return a + b;
      ALU_SUB:              return a - b;
      ALU_XOR:              return a ^ b;
      ALU_OR:               return a | b;
      ALU_AND:              return a & b;
      ALU_SHIFTL,
      ALU_SHIFTR,
      ALU_SHIFTR_ARITH:     return a;
      ALU_LESS_THAN:        return {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_LESS_THAN_SIGNED: return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:              return '0;
    endcase
  endfunction

  assign shamt      = SrcB[SHW-1:0];
  assign single_res = single_op(ALUControl, SrcA, SrcB);

  always_comb begin
    unique case (op_q)
      ALU_SHIFTL:       acc_step = {acc_q[WIDTH-2:0], 1'b0};
      ALU_SHIFTR:       acc_step = {1'b0, acc_q[WIDTH-1:1]};
      ALU_SHIFTR_ARITH: acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default:          acc_step = acc_q;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a hold value first so no path infers a latch;
    // combinational logic uses blocking '=', the register block uses '<='.
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = ALUControl;
          if (is_shift(ALUControl) && (shamt != '0)) begin
            acc_d   = SrcA;
            cnt_d   = shamt;
            state_d = ST_SHIFT;
          end else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - SHW'(1);
        // The last step's value goes straight to the result register.
        if (cnt_q == SHW'(1)) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= ALU_NONE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: directed ops with literal expectations, plus a
// countdown-based behavioural model compared against the outputs every cycle.
module tb_alu_seq_exec;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   ALUControl;
  logic [W-1:0] SrcA, SrcB;
  logic         ready, done, Zero;
  logic [W-1:0] ALUResult;

  int total = 0;
  int bad   = 0;

  alu_seq_exec #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ALUControl(ALUControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ready     (ready),
    .done      (done),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [W-1:0] model_result(input logic [3:0] c, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    int n;
    n = int'(b % W);
    case (c)
      ALU_NONE:             return b;
      ALU_ADD:              return a + b;
      ALU_SUB:              return a - b;
      ALU_XOR:              return a ^ b;
      ALU_OR:               return a | b;
      ALU_AND:              return a & b;
      ALU_SHIFTL:           return a << n;
      ALU_SHIFTR:           return a >> n;
      ALU_SHIFTR_ARITH:     return W'($signed(a) >>> n);
      ALU_LESS_THAN:        return (a < b) ? W'(1) : W'(0);
      ALU_LESS_THAN_SIGNED: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default:              return '0;
    endcase
  endfunction

  logic         m_done = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_res  = '0;
  logic [W-1:0] m_pend = '0;
  logic         m_zero = 1'b1;
  bit           model_on = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] r;
    int           n;
    bit           sh;
    r  = model_result(ALUControl, SrcA, SrcB);
    n  = int'(SrcB % W);
    sh = (ALUControl == ALU_SHIFTL) || (ALUControl == ALU_SHIFTR) || (ALUControl == ALU_SHIFTR_ARITH);
    if (rst) begin
      m_done <= 1'b0;
      m_left <= 0;
      m_res  <= '0;
      m_zero <= 1'b1;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= m_pend;
        m_zero <= (m_pend == '0);
      end
    end else if (start) begin
      if (sh && n != 0) begin
        m_left <= n;
        m_pend <= r;
      end else begin
        m_done <= 1'b1;
        m_res  <= r;
        m_zero <= (r == '0);
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_ready", W'(ready), W'(!m_done && m_left == 0));
      check("model_done",  W'(done),  W'(m_done));
      check("model_res",   ALUResult, m_res);
      check("model_zero",  W'(Zero),  W'(m_zero));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ready();
    int guard = 0;
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) check("ready_timeout", W'(ready), W'(1));
  endtask

  task automatic do_op(input string name, input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_lat,
                       input bit inject);
    int lat = 0;
    wait_ready();
    start = 1'b1; ALUControl = c; SrcA = a; SrcB = b;
    @(posedge clk);
    while (lat < 64) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (lat == 1) begin
        start = 1'b0; SrcA = $urandom; SrcB = $urandom;
      end
      if (inject && lat == 2) begin
        start = 1'b1; ALUControl = ALU_ADD; SrcA = 32'h1111_0000; SrcB = 32'h0000_2222;
      end
      if (inject && lat == 3) start = 1'b0;
    end
    start = 1'b0;
    check({name, "_latency"}, W'(lat), W'(exp_lat));
    check({name, "_result"}, ALUResult, exp_res);
    check({name, "_zero"}, W'(Zero), W'(exp_res == '0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; ALUControl = ALU_ADD; SrcA = 32'd5; SrcB = 32'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    model_on = 1'b1;
    check("reset_ready", W'(ready), W'(1));
    check("reset_done",  W'(done),  W'(0));
    check("reset_res",   ALUResult, 32'h0);
    check("reset_zero",  W'(Zero),  W'(1));
    @(negedge clk);
    check("no_accept_in_reset", W'(done), W'(0));

    do_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1'b0);
    do_op("sub_wrap", ALU_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 1, 1'b0);
    do_op("slt",  ALU_LESS_THAN_SIGNED, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 1'b0);
    do_op("sltu", ALU_LESS_THAN,        32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1'b0);
    do_op("sra4",  ALU_SHIFTR_ARITH, 32'h8000_0000, 32'd4, 32'hF800_0000, 5, 1'b0);
    do_op("sll31", ALU_SHIFTL, 32'h1, 32'd31, 32'h8000_0000, 32, 1'b0);
    do_op("srl1",  ALU_SHIFTR, 32'h8000_0000, 32'h21, 32'h4000_0000, 2, 1'b0);
    do_op("sll0",  ALU_SHIFTL, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1, 1'b0);
    do_op("none",  ALU_NONE, 32'h1, 32'hCAFE, 32'hCAFE, 1, 1'b0);
    do_op("or",    ALU_OR,  32'hF0, 32'h0F, 32'hFF, 1, 1'b0);
    do_op("and",   ALU_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1, 1'b0);
    do_op("undef", 4'hF, 32'h1234, 32'h5678, 32'h0, 1, 1'b0);
    do_op("busy_sll8", ALU_SHIFTL, 32'h3, 32'd8, 32'h300, 9, 1'b1);
    do_op("xor_eq", ALU_XOR, 32'h1234, 32'h1234, 32'h0, 1, 1'b0);

    // start held high: the model tracks each acceptance cycle by cycle
    wait_ready();
    start = 1'b1; ALUControl = ALU_ADD; SrcA = 32'd2; SrcB = 32'd3;
    @(negedge clk);
    SrcA = 32'd7;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("held_start_res", ALUResult, 32'd10);

    // reset in the third SHIFT cycle aborts the shift
    repeat (2) @(negedge clk);
    wait_ready();
    start = 1'b1; ALUControl = ALU_SHIFTL; SrcA = 32'h5; SrcB = 32'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", W'(ready), W'(1));
    check("abort_done",  W'(done),  W'(0));
    check("abort_res",   ALUResult, 32'h0);
    check("abort_zero",  W'(Zero),  W'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_done", W'(done), W'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Sequential ALU execute unit. It consumes the 4-bit `ALUControl` code produced by the ALU decoder, along with two operands, and returns a registered result and `Zero` flag. It sits in the execute stage of the multi-cycle core variant. Shifts are computed iteratively, one bit position per cycle, to save area. All other operations complete in one cycle.

## Interface
Parameters:
- `WIDTH`, 32: datapath width. Must be a power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width.

Ports:
- `clk`  in  1  clock. All state updates on its rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `start`  in  1  request. Accepted only when `ready`=1.
- `ALUControl`  in  4  operation code, using the `ALU_*` macros in define.v.
- `SrcA`  in  WIDTH  operand A.
- `SrcB`  in  WIDTH  operand B. For shifts, the shift amount is `SrcB[SHW-1:0]`.
- `ready`  out  1  unit idle; a `start` in this cycle is accepted.
- `done`  out  1  one-cycle pulse; `ALUResult` and `Zero` are valid.
- `ALUResult`  out  WIDTH  registered result. Held until the next acceptance.
- `Zero`  out  1  registered; equals (`ALUResult` == 0).

## Operation
- States: IDLE, SHIFT, DONE. `ready` = (state == IDLE). `done` = (state == DONE).
- Acceptance: `start`=1 while in IDLE. At that edge, latch `ALUControl`, `SrcA` and `SrcB`. A `start` in SHIFT or DONE is ignored; there is no queueing.
- Single-cycle ops, IDLE → DONE. The result is written at the acceptance edge:
  - `ALU_ADD`: A+B, modulo 2^WIDTH.
  - `ALU_SUB`: A−B, modulo 2^WIDTH.
  - `ALU_XOR`, `ALU_OR`, `ALU_AND`: bitwise.
  - `ALU_LESS_THAN_SIGNED`: {0…,A<B signed}.
  - `ALU_LESS_THAN`: {0…,A<B unsigned}.
  - `ALU_NONE`: B pass-through.
  - Any undefined code: result 0.
- Shift ops: `ALU_SHIFTL`, `ALU_SHIFTR`, `ALU_SHIFTR_ARITH`.
  - shamt == 0: IDLE → DONE, result = A.
  - shamt n ≥ 1: IDLE → SHIFT. At acceptance, set acc = A and cnt = n.
  - Each SHIFT cycle: shift acc by one position and decrement cnt.
    - SLL fills with 0.
    - SRL fills with 0.
    - SRA replicates the MSB.
  - When cnt reaches 0, move to DONE. `ALUResult` = acc.
- DONE always returns to IDLE on the next edge.
- `Zero` is registered on the same edge as `ALUResult`. `ALU_XOR` with `Zero`=1 signals branch equality.
- Reset mid-operation aborts the op: state → IDLE, no `done` pulse for the aborted op.

## Timing
- Reset values:
  - state = IDLE, so `ready`=1 after the reset edge.
  - `done`=0.
  - `ALUResult`=0.
  - `Zero`=1.
  - cnt = 0, acc = 0.
- Latency, for acceptance at edge k:
  - Non-shift or shamt=0: `done` is high in the cycle after edge k.
  - Shift with shamt n ≥ 1: `done` is high in the cycle after edge k+n.
- Throughput:
  - Non-shift: one op per 2 cycles. `ready` is low during DONE.
  - Shift: one op per n+2 cycles.
- `ALUResult` and `Zero` are updated only at the edge entering DONE. They are stable from DONE until the next completion.
- `start` held high continuously: a new op is accepted each time `ready`=1, using the inputs sampled at that edge.
- Operand changes after acceptance have no effect on the in-flight op.

## Test plan
- Reset:
  - Stimulus: assert `rst` for 2 cycles, with `start`=1 during reset.
  - Response: `ready`=1, `done`=0, `ALUResult`=0, `Zero`=1.
  - No op is accepted during reset.
- Arithmetic wrap:
  - `ALU_ADD`, A=0xFFFFFFFF, B=1 → one cycle later `done`=1, `ALUResult`=0, `Zero`=1.
  - `ALU_SUB`, A=0, B=1 → `ALUResult`=0xFFFFFFFF, `Zero`=0.
- Compares:
  - `ALU_LESS_THAN_SIGNED`, A=0xFFFFFFFF, B=1 → `ALUResult`=1.
  - `ALU_LESS_THAN` with the same operands → `ALUResult`=0.
- Iterative shifts:
  - `ALU_SHIFTR_ARITH`, A=0x80000000, B=4 → `done` exactly 5 cycles after the acceptance edge, `ALUResult`=0xF8000000.
  - `ALU_SHIFTL`, A=1, B=31 → `ALUResult`=0x80000000 after 32 cycles.
  - shamt=0 → 1 cycle, `ALUResult`=A.
- Busy handling:
  - Stimulus: during an SLL with B=8, pulse `start` with `ALU_ADD` and change `SrcA` while in SHIFT.
  - Response: the second request is ignored and the shift result is unchanged.
  - Then `ALU_XOR`, A=B=0x1234 → `Zero`=1.
- Reset mid-shift:
  - Stimulus: assert `rst` in the 3rd SHIFT cycle.
  - Response: the next cycle is IDLE, `ready`=1, no `done` pulse, `ALUResult`=0.
